// File: rtl/data_mem_port_pkg.sv
// Shared definitions for the data-memory port: access size codes and FSM state codes.
// Size 2'b11 is not given its own code; every consumer treats it as a word.
package data_mem_port_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: picks the addressed lane out of a RAM word and sign/zero extends it to 32 bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by whoever registers it.
module mem_load_ext
  import data_mem_port_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select then extension; word (and size 11) passes through and ignores uns.
  always_comb begin
    lane_b = rdata[{addr, 3'b000} +: 8];
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    case (size)
      SZ_B:    result = {{24{~uns & lane_b[7]}}, lane_b};
      SZ_H:    result = {{16{~uns & lane_h[15]}}, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// data_mem_port: one-at-a-time load/store responder driving a word-wide byte-enabled synchronous RAM.
// Latency: accept at T, RAM strobe at T+1, rsp_valid pulse at T+3 for loads and stores alike.
// Backpressure: req_ready only while IDLE, req_valid held until accepted; DATA_MEM_MISALIGN_CHECK_EN adds misalign errors.
module data_mem_port
  import data_mem_port_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_uns,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [31:0]   rsp_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  state_e        state_q;
  state_e        state_nxt;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic [31:0]   load_res;
  logic          misaligned;

  // Address bits above the RAM's reach are deliberately dropped.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_ready = (state_q == IDLE);
  assign ram_addr  = addr_q[AW+1:2];
  assign ram_wdata = st_data;

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  logic rsp_err_q;
  assign rsp_err = rsp_err_q;
  // Half on an odd byte, or word (incl. size 11) off a word boundary, is rejected.
  always_comb misaligned = ((size_q == SZ_H) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign rsp_err    = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Store byte enables and lane-replicated store data from the latched request.
  always_comb begin
    st_mask = 4'b1111;
    st_data = wdata_q;
    case (size_q)
      SZ_B: begin
        st_mask = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        st_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next state and RAM strobes; strobes are gated by rst so a reset cycle never writes.
  always_comb begin
    state_nxt = state_q;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = WAIT;
        ram_en    = ~rst & ~misaligned;
        if (ram_en && we_q) ram_we = st_mask;
      end
      WAIT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mem_load_ext u_load_ext (
    .rdata  (ram_rdata),
    .addr   (addr_q[1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .result (load_res)
  );

  // Request capture on accept, and response/MDR update when the RAM word arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_uns;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
      end
      if (state_q == WAIT) begin
        rsp_valid <= 1'b1;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        rsp_err_q <= misaligned;
`endif
        if (!we_q && !misaligned) rsp_rdata <= load_res;
      end
    end
  end

endmodule
